prog_prio_encoder_pipe: RTL and testbench

- Pipelined, programmable-priority successor to the team's combinational WIDTH-to-LOG_W priority encoder.
- Accepts a WIDTH-bit request vector per transaction over a valid/ready handshake.
- Returns the index of the winning set bit under one of four priority modes. One mode is round-robin with an internal pointer.
- Sits in front of arbitration/scheduling logic and decouples the wide search from the caller's timing path with two register stages.

---
 rtl/prog_prio_encoder_pipe_if.sv | 37 +++
 rtl/prog_prio_encoder_pipe.sv | 133 +++++++++++++
 tb/tb_prog_prio_encoder_pipe.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_prio_encoder_pipe_if.sv
// Request/result handshake bundle for the programmable priority encoder.
// master drives requests and consumes results; slave is the encoder.
interface prog_prio_encoder_pipe_if #(
  parameter int WIDTH = 1024,
  parameter int LOG_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_req;
  logic [LOG_W-1:0] in_base;
  logic             out_valid;
  logic             out_ready;
  logic             out_found;
  logic [LOG_W-1:0] out_idx;

  modport master (
    output in_valid,
    output in_req,
    output in_base,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_found,
    input  out_idx
  );

  modport slave (
    input  in_valid,
    input  in_req,
    input  in_base,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_found,
    output out_idx
  );
endinterface

// File: rtl/prog_prio_encoder_pipe.sv
// Two-stage elastic priority encoder with programmable base,
// round-robin, highest-index and lowest-index modes.
module prog_prio_encoder_pipe #(
  parameter int WIDTH = 1024,
  parameter int LOG_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               cfg_mode,
  prog_prio_encoder_pipe_if.slave  bus,
  output logic [LOG_W-1:0]         rr_ptr
);

  typedef enum logic [1:0] {
    MODE_BASE = 2'd0,
    MODE_RR   = 2'd1,
    MODE_HI   = 2'd2,
    MODE_LO   = 2'd3
  } mode_e;

  typedef struct packed {
    logic [WIDTH-1:0] req;
    logic [WIDTH-1:0] msk;
    mode_e            mode;
  } s1_t;

  typedef struct packed {
    logic             found;
    logic [LOG_W-1:0] idx;
    logic             rr;
  } s2_t;

  function automatic logic [LOG_W-1:0] lo_idx(
    input logic [WIDTH-1:0] v
  );
    lo_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) lo_idx = LOG_W'(i);
    end
  endfunction

  function automatic logic [LOG_W-1:0] hi_idx(
    input logic [WIDTH-1:0] v
  );
    hi_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) hi_idx = LOG_W'(i);
    end
  endfunction

  logic             s1_vld_q;
  logic             s2_vld_q;
  s1_t              s1_q;
  s1_t              s1_d;
  s2_t              s2_q;
  s2_t              s2_d;
  logic [LOG_W-1:0] rr_ptr_q;
  logic [LOG_W-1:0] rr_ptr_d;

  logic             s1_rdy;
  logic             s2_rdy;
  logic             rr_busy;
  logic             acc;
  logic             s1_adv;
  logic             emit;
  logic [LOG_W-1:0] base;

  always_comb begin
    s2_rdy  = !s2_vld_q || bus.out_ready;
    s1_rdy  = !s1_vld_q || s2_rdy;
    // one RR grant in flight at a time keeps rr_ptr current
    rr_busy = (mode_e'(cfg_mode) == MODE_RR)
              && (s1_vld_q || s2_vld_q);
    acc     = bus.in_valid && s1_rdy && !rr_busy;
    s1_adv  = s1_vld_q && s2_rdy;
    emit    = s2_vld_q && bus.out_ready;
  end

  always_comb begin
    base = bus.in_base;
    if (mode_e'(cfg_mode) == MODE_RR) base = rr_ptr_q;
    s1_d      = '0;
    s1_d.req  = bus.in_req;
    s1_d.msk  = bus.in_req & ({WIDTH{1'b1}} << base);
    s1_d.mode = mode_e'(cfg_mode);
  end

  always_comb begin
    s2_d       = '0;
    s2_d.found = |s1_q.req;
    s2_d.rr    = (s1_q.mode == MODE_RR);
    unique case (1'b1)
      (s1_q.mode == MODE_HI): s2_d.idx = hi_idx(s1_q.req);
      (s1_q.mode == MODE_LO): s2_d.idx = lo_idx(s1_q.req);
      default: begin
        if (|s1_q.msk) s2_d.idx = lo_idx(s1_q.msk);
        else           s2_d.idx = lo_idx(s1_q.req);
      end
    endcase
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (emit && s2_q.found && s2_q.rr) begin
      rr_ptr_d = s2_q.idx + LOG_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s2_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      if (s1_rdy) s1_vld_q <= acc;
      if (s2_rdy) s2_vld_q <= s1_vld_q;
      if (s1_adv) s2_q <= s2_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) s1_q <= s1_d;
  end

  assign bus.in_ready  = s1_rdy && !rr_busy;
  assign bus.out_valid = s2_vld_q;
  assign bus.out_found = s2_q.found;
  assign bus.out_idx   = s2_q.idx;
  assign rr_ptr        = rr_ptr_q;

endmodule

// File: tb/tb_prog_prio_encoder_pipe.sv
// Directed bench for prog_prio_encoder_pipe at WIDTH 16,
// plus a WIDTH 1024 smoke instance.
module tb_prog_prio_encoder_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cfg_mode;
  logic [1:0] cfg_mode_w;
  logic [3:0] rr_ptr;
  logic [9:0] rr_w;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  prog_prio_encoder_pipe_if #(.WIDTH(16), .LOG_W(4)) b ();
  prog_prio_encoder_pipe_if #(.WIDTH(1024), .LOG_W(10)) w ();

  prog_prio_encoder_pipe #(.WIDTH(16), .LOG_W(4)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_mode (cfg_mode),
    .bus      (b),
    .rr_ptr   (rr_ptr)
  );

  prog_prio_encoder_pipe #(.WIDTH(1024), .LOG_W(10)) u_wide (
    .clk      (clk),
    .rst      (rst),
    .cfg_mode (cfg_mode_w),
    .bus      (w),
    .rr_ptr   (rr_w)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // cfg_mode must only move while the pipe is drained
  int         inflight = 0;
  logic [1:0] mode_prev;
  always @(posedge clk) begin
    if (rst) begin
      inflight = 0;
    end else begin
      if (cfg_mode !== mode_prev && inflight != 0)
        $error("cfg_mode changed with %0d in flight", inflight);
      inflight = inflight
               + int'(b.in_valid && b.in_ready)
               - int'(b.out_valid && b.out_ready);
    end
    mode_prev = cfg_mode;
  end

  task automatic xact(
    input string      tag,
    input logic [1:0] m,
    input logic [15:0] req,
    input logic [3:0] base,
    input logic       fnd,
    input logic [3:0] idx
  );
    int n;
    cfg_mode    = m;
    b.in_req    = req;
    b.in_base   = base;
    b.out_ready = 1'b1;
    b.in_valid  = 1'b1;
    n = 0;
    while (!b.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) check({tag, "_rdy_to"}, 0, 1);
    @(posedge clk); #1;
    b.in_valid = 1'b0;
    check({tag, "_v_t1"}, b.out_valid, 0);
    if (m == 2'd1) check({tag, "_irdy_t1"}, b.in_ready, 0);
    @(posedge clk); #1;
    check({tag, "_v_t2"}, b.out_valid, 1);
    check({tag, "_found"}, b.out_found, fnd);
    check({tag, "_idx"}, b.out_idx, idx);
    if (m == 2'd1) check({tag, "_irdy_t2"}, b.in_ready, 0);
    @(posedge clk); #1;
  endtask

  task automatic xw(
    input string        tag,
    input logic [1:0]   m,
    input logic [1023:0] req,
    input logic [9:0]   base,
    input logic [9:0]   idx
  );
    cfg_mode_w  = m;
    w.in_req    = req;
    w.in_base   = base;
    w.out_ready = 1'b1;
    w.in_valid  = 1'b1;
    check({tag, "_irdy"}, w.in_ready, 1);
    @(posedge clk); #1;
    w.in_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, "_v"}, w.out_valid, 1);
    check({tag, "_found"}, w.out_found, 1);
    check({tag, "_idx"}, w.out_idx, idx);
    @(posedge clk); #1;
  endtask

  logic [15:0] bv [10] = '{
    16'h0000, 16'h0001, 16'h8000, 16'h00F0, 16'h1200,
    16'h0006, 16'hFFFF, 16'h4000, 16'h0A00, 16'h0400
  };
  logic [3:0] bi [10] = '{
    4'd0, 4'd0, 4'd15, 4'd4, 4'd9,
    4'd1, 4'd0, 4'd14, 4'd9, 4'd10
  };
  logic bf [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1};

  logic [1023:0] wreq;

  initial begin
    rst         = 1'b1;
    cfg_mode    = 2'd2;
    cfg_mode_w  = 2'd3;
    b.in_valid  = 1'b0;
    b.in_req    = '0;
    b.in_base   = '0;
    b.out_ready = 1'b1;
    w.in_valid  = 1'b0;
    w.in_req    = '0;
    w.in_base   = '0;
    w.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_ovalid", b.out_valid, 0);
    check("rst_found", b.out_found, 0);
    check("rst_idx", b.out_idx, 0);
    check("rst_rr", rr_ptr, 0);
    check("rst_irdy", b.in_ready, 1);

    xact("m2_lat", 2'd2, 16'h0012, 4'd0, 1, 4'd4);

    xact("m0_b5", 2'd0, 16'h0104, 4'd5, 1, 4'd8);
    xact("m0_b9", 2'd0, 16'h0104, 4'd9, 1, 4'd2);
    xact("m0_b8", 2'd0, 16'h0104, 4'd8, 1, 4'd8);

    xact("rr0", 2'd1, 16'h8001, 4'd0, 1, 4'd0);
    check("rr0_ptr", rr_ptr, 1);
    check("rr0_irdy", b.in_ready, 1);
    xact("rr1", 2'd1, 16'h8001, 4'd0, 1, 4'd15);
    check("rr1_ptr", rr_ptr, 0);
    xact("rr2", 2'd1, 16'h8001, 4'd0, 1, 4'd0);
    check("rr2_ptr", rr_ptr, 1);
    xact("rr3", 2'd1, 16'h8001, 4'd0, 1, 4'd15);
    check("rr3_ptr", rr_ptr, 0);

    xact("rr_b4", 2'd1, 16'h0010, 4'd0, 1, 4'd4);
    check("rr_b4_ptr", rr_ptr, 5);
    for (int m = 0; m < 4; m++) begin
      xact($sformatf("empty_m%0d", m), 2'(m),
           16'h0000, 4'd3, 0, 4'd0);
      check($sformatf("empty_m%0d_rr", m), rr_ptr, 5);
    end
    xact("m3_top", 2'd3, 16'h8000, 4'd0, 1, 4'd15);
    xact("rr_wrap", 2'd1, 16'h8000, 4'd0, 1, 4'd15);
    check("rr_wrap_ptr", rr_ptr, 0);
    xact("rr_b4b", 2'd1, 16'h0010, 4'd0, 1, 4'd4);
    check("rr_b4b_ptr", rr_ptr, 5);

    // backpressure stream, mode 3
    cfg_mode = 2'd3;
    fork
      begin
        int n;
        @(posedge clk); #2;
        for (int i = 0; i < 10; i++) begin
          b.in_req   = bv[i];
          b.in_valid = 1'b1;
          n = 0;
          while (!b.in_ready && n < 300) begin
            @(posedge clk); #2; n++;
          end
          if (n >= 300) check("bp_in_to", 0, 1);
          @(posedge clk); #2;
        end
        b.in_valid = 1'b0;
      end
      begin
        int   k;
        int   cyc;
        logic stall;
        logic pf;
        logic [3:0] pi;
        k = 0; cyc = 0; stall = 1'b0;
        pf = 1'b0; pi = '0;
        while (k < 10 && cyc < 300) begin
          @(posedge clk); #1; cyc++;
          if (stall) begin
            check("bp_hold_v", b.out_valid, 1);
            check("bp_hold_f", b.out_found, pf);
            check("bp_hold_i", b.out_idx, pi);
          end
          b.out_ready = 1'($urandom_range(0, 1));
          if (b.out_valid && b.out_ready) begin
            check($sformatf("bp_f%0d", k), b.out_found, bf[k]);
            check($sformatf("bp_i%0d", k), b.out_idx, bi[k]);
            k++;
          end
          stall = b.out_valid && !b.out_ready;
          pf    = b.out_found;
          pi    = b.out_idx;
        end
        if (k < 10) check("bp_out_to", k, 10);
      end
    join
    @(posedge clk); #1;
    b.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_drained", b.out_valid, 0);

    // fill both stages, then reset mid-flight
    cfg_mode    = 2'd0;
    b.out_ready = 1'b0;
    b.in_req    = 16'h0001;
    b.in_base   = 4'd0;
    b.in_valid  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("full_irdy", b.in_ready, 0);
    check("full_ovalid", b.out_valid, 1);
    b.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    b.out_ready = 1'b1;
    check("mrst_rr", rr_ptr, 0);
    check("mrst_found", b.out_found, 0);
    check("mrst_idx", b.out_idx, 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mrst_ov%0d", i), b.out_valid, 0);
      @(posedge clk); #1;
    end
    check("mrst_irdy", b.in_ready, 1);

    // WIDTH 1024 smoke
    wreq = '0;
    wreq[1000] = 1'b1;
    wreq[3]    = 1'b1;
    xw("w_m0_wrap", 2'd0, wreq, 10'd1001, 10'd3);
    xw("w_m0_mid", 2'd0, wreq, 10'd500, 10'd1000);
    xw("w_m2", 2'd2, wreq, 10'd0, 10'd1000);
    xw("w_m3", 2'd3, wreq, 10'd0, 10'd3);
    xw("w_rr", 2'd1, wreq, 10'd0, 10'd3);
    check("w_rr_ptr", rr_w, 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
